// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the IF/MEM unified-RAM port arbiter.
package mem_arb_pkg;

  localparam int unsigned ARB_ADDR_W       = 32;
  localparam int unsigned ARB_DATA_W       = 32;
  localparam int unsigned ARB_MEM_LATENCY  = 2;
  localparam int unsigned ARB_STARVE_LIMIT = 4;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } arb_state_e;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_IF,
    GNT_MEM
  } arb_gnt_e;

endpackage

// File: rtl/arb_wait_counter.sv
// Loadable saturating down-counter with a zero flag; used for RAM latency
// and, when enabled, for IF starvation tracking.
module arb_wait_counter
  import mem_arb_pkg::*;
#(
  parameter int unsigned      WIDTH   = 2,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      count_d = count_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= RST_VAL;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates IF and MEM stage access to one single-port synchronous RAM.
// Optional IF starvation guard: define ARB_STARVE_GUARD_EN.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W       = ARB_ADDR_W,
  parameter int unsigned DATA_W       = ARB_DATA_W,
  parameter int unsigned MEM_LATENCY  = ARB_MEM_LATENCY,
  parameter int unsigned STARVE_LIMIT = ARB_STARVE_LIMIT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              mem_rd,
  input  logic              mem_wr,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_ready,
  output logic              stall_if,
  output logic              stall_mem,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam int unsigned WAIT_W = $clog2(MEM_LATENCY + 1);

  arb_state_e        state_q, state_d;
  arb_gnt_e          gnt_q, gnt_d;
  logic              we_q, we_d;
  logic              ram_en_q, ram_en_d;
  logic              ram_we_q, ram_we_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;
  logic              if_ready_q, if_ready_d;
  logic              mem_ready_q, mem_ready_d;

  logic mem_req;
  logic force_if;
  logic grant_if, grant_mem;
  logic wait_load, wait_dec, wait_zero;

  assign mem_req = mem_rd | mem_wr;

  // Counter is loaded on grant so it has already stepped once by the end of ISSUE.
  arb_wait_counter #(
    .WIDTH   (WAIT_W),
    .RST_VAL ('0)
  ) u_wait_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (wait_load),
    .load_val_i (WAIT_W'(MEM_LATENCY)),
    .dec_i      (wait_dec),
    .zero_o     (wait_zero)
  );

`ifdef ARB_STARVE_GUARD_EN
  localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 1);

  logic starve_zero;

  arb_wait_counter #(
    .WIDTH   (STARVE_W),
    .RST_VAL (STARVE_W'(STARVE_LIMIT))
  ) u_starve_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (grant_if | (grant_mem & ~if_req)),
    .load_val_i (STARVE_W'(STARVE_LIMIT)),
    .dec_i      (grant_mem & if_req),
    .zero_o     (starve_zero)
  );

  assign force_if = starve_zero & if_req;
`else
  assign force_if = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    we_d        = we_q;
    ram_en_d    = 1'b0;
    ram_we_d    = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;
    if_ready_d  = 1'b0;
    mem_ready_d = 1'b0;
    grant_if    = 1'b0;
    grant_mem   = 1'b0;
    wait_load   = 1'b0;
    wait_dec    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (mem_req && !force_if) begin
          grant_mem = 1'b1;
        end else if (if_req) begin
          grant_if = 1'b1;
        end
        if (grant_mem || grant_if) begin
          state_d     = ISSUE;
          gnt_d       = grant_mem ? GNT_MEM : GNT_IF;
          we_d        = grant_mem & mem_wr;
          ram_en_d    = 1'b1;
          ram_we_d    = grant_mem & mem_wr;
          ram_addr_d  = grant_mem ? mem_addr : if_addr;
          ram_wdata_d = grant_mem ? mem_wdata : ram_wdata_q;
          wait_load   = 1'b1;
        end
      end
      ISSUE: begin
        wait_dec = 1'b1;
        state_d  = WAIT;
      end
      WAIT: begin
        if (wait_zero) begin
          state_d = RESP;
          if (gnt_q == GNT_IF) begin
            if_rdata_d = ram_rdata;
            if_ready_d = 1'b1;
          end else if (gnt_q == GNT_MEM) begin
            if (!we_q) begin
              mem_rdata_d = ram_rdata;
            end
            mem_ready_d = 1'b1;
          end
        end else begin
          wait_dec = 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
        gnt_d   = GNT_NONE;
      end
      default: begin
        state_d = IDLE;
        gnt_d   = GNT_NONE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      gnt_q       <= GNT_NONE;
      we_q        <= 1'b0;
      ram_en_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
      if_ready_q  <= 1'b0;
      mem_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      we_q        <= we_d;
      ram_en_q    <= ram_en_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
      if_ready_q  <= if_ready_d;
      mem_ready_q <= mem_ready_d;
    end
  end

  assign ram_en    = ram_en_q;
  assign ram_we    = ram_we_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
  assign if_rdata  = if_rdata_q;
  assign if_ready  = if_ready_q;
  assign mem_rdata = mem_rdata_q;
  assign mem_ready = mem_ready_q;
  assign stall_if  = if_req & ~if_ready_q;
  assign stall_mem = mem_req & ~mem_ready_q;

  a_rd_wr_excl: assert property (@(posedge clk) disable iff (!rst_n) !(mem_rd && mem_wr));
  a_params:     assert property (@(posedge clk) (MEM_LATENCY >= 1) && (STARVE_LIMIT >= 1));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a 2-cycle-latency RAM model.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ready;
  logic        mem_rd;
  logic        mem_wr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        stall_if;
  logic        stall_mem;
  logic        ram_en;
  logic        ram_we;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;

  int n_tests = 0;
  int n_fail  = 0;

`ifdef ARB_STARVE_GUARD_EN
  localparam int EXP_MEM_CNT = 5;
  localparam int EXP_IF_CNT  = 1;
  localparam int EXP_IF_IDX  = 23;
`else
  localparam int EXP_MEM_CNT = 6;
  localparam int EXP_IF_CNT  = 0;
  localparam int EXP_IF_IDX  = -1;
`endif

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W       (32),
    .DATA_W       (32),
    .MEM_LATENCY  (2),
    .STARVE_LIMIT (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_rdata  (if_rdata),
    .if_ready  (if_ready),
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .stall_if  (stall_if),
    .stall_mem (stall_mem),
    .ram_en    (ram_en),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
  );

  // RAM: command sampled at edge E, read data stable by edge E+2
  logic [31:0] ram [0:1023];
  logic [31:0] pipe0, pipe1;
  assign ram_rdata = pipe1;

  always @(posedge clk) begin
    if (!rst_n) begin
      ram[25]  <= 32'h2008_0004;
      ram[26]  <= 32'h8C09_0008;
      ram[125] <= 32'd30;
    end else if (ram_en) begin
      if (ram_we) ram[ram_addr[11:2]] <= ram_wdata;
      else        pipe0 <= ram[ram_addr[11:2]];
    end
    pipe1 <= pipe0;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  int mem_cnt, if_cnt, if_idx, stall_low;
  bit got_ready;

  initial begin
    rst_n = 1'b0; if_req = 1'b0; if_addr = '0;
    mem_rd = 1'b0; mem_wr = 1'b0; mem_addr = '0; mem_wdata = '0;
    cyc(3);
    check_eq("rst_ram_en",    32'(ram_en), 0);
    check_eq("rst_ram_addr",  ram_addr, 0);
    check_eq("rst_if_ready",  32'(if_ready), 0);
    check_eq("rst_mem_ready", 32'(mem_ready), 0);
    check_eq("rst_if_rdata",  if_rdata, 0);
    check_eq("rst_mem_rdata", mem_rdata, 0);
    rst_n = 1'b1;
    cyc(2);

    // 1: single IF read
    if_req = 1'b1; if_addr = 32'h64;
    cyc(1);
    check_eq("t1_en", 32'(ram_en), 1);
    check_eq("t1_we", 32'(ram_we), 0);
    check_eq("t1_addr", ram_addr, 32'h64);
    check_eq("t1_stall_g", 32'(stall_if), 1);
    cyc(1);
    check_eq("t1_en_off", 32'(ram_en), 0);
    check_eq("t1_stall_g1", 32'(stall_if), 1);
    cyc(1);
    check_eq("t1_rdy_early", 32'(if_ready), 0);
    check_eq("t1_stall_g2", 32'(stall_if), 1);
    cyc(1);
    check_eq("t1_rdy", 32'(if_ready), 1);
    check_eq("t1_rdata", if_rdata, 32'h2008_0004);
    check_eq("t1_stall_g3", 32'(stall_if), 0);
    check_eq("t1_mem_rdy", 32'(mem_ready), 0);
    if_req = 1'b0;
    cyc(1);
    check_eq("t1_rdy_off", 32'(if_ready), 0);
    cyc(1);
    check_eq("t1_no_reissue", 32'(ram_en), 0);

    // 2: simultaneous IF and MEM, MEM first
    if_req = 1'b1; if_addr = 32'h68;
    mem_rd = 1'b1; mem_addr = 32'h1F4;
    cyc(1);
    check_eq("t2_addr_mem", ram_addr, 32'h1F4);
    check_eq("t2_en", 32'(ram_en), 1);
    check_eq("t2_stall_mem", 32'(stall_mem), 1);
    cyc(3);
    check_eq("t2_mem_rdy", 32'(mem_ready), 1);
    check_eq("t2_mem_rdata", mem_rdata, 32'd30);
    check_eq("t2_if_rdy_low", 32'(if_ready), 0);
    check_eq("t2_stall_if", 32'(stall_if), 1);
    mem_rd = 1'b0;
    cyc(1);
    check_eq("t2_en_g4", 32'(ram_en), 0);
    cyc(1);
    check_eq("t2_en_g5", 32'(ram_en), 1);
    check_eq("t2_addr_if", ram_addr, 32'h68);
    cyc(3);
    check_eq("t2_if_rdy", 32'(if_ready), 1);
    check_eq("t2_if_rdata", if_rdata, 32'h8C09_0008);
    if_req = 1'b0;
    cyc(2);

    // 3: write then read back
    mem_wr = 1'b1; mem_addr = 32'h10; mem_wdata = 32'hDEAD_BEEF;
    cyc(1);
    check_eq("t3_en", 32'(ram_en), 1);
    check_eq("t3_we", 32'(ram_we), 1);
    check_eq("t3_addr", ram_addr, 32'h10);
    check_eq("t3_wdata", ram_wdata, 32'hDEAD_BEEF);
    cyc(1);
    check_eq("t3_we_off", 32'(ram_we), 0);
    cyc(2);
    check_eq("t3_wr_rdy", 32'(mem_ready), 1);
    check_eq("t3_rdata_held", mem_rdata, 32'd30);
    mem_wr = 1'b0; mem_rd = 1'b1; mem_wdata = '0;
    cyc(1);
    check_eq("t3_resp_no_en", 32'(ram_en), 0);
    cyc(1);
    check_eq("t3_rd_en", 32'(ram_en), 1);
    check_eq("t3_rd_we", 32'(ram_we), 0);
    cyc(3);
    check_eq("t3_rd_rdy", 32'(mem_ready), 1);
    check_eq("t3_rd_data", mem_rdata, 32'hDEAD_BEEF);
    mem_rd = 1'b0;
    cyc(2);

    // 4: reset during WAIT aborts, then re-issue
    if_req = 1'b1; if_addr = 32'h64;
    cyc(2);
    rst_n = 1'b0;
    #1;
    check_eq("t4_en_async", 32'(ram_en), 0);
    check_eq("t4_we_async", 32'(ram_we), 0);
    check_eq("t4_addr_async", ram_addr, 0);
    check_eq("t4_rdy_async", 32'(if_ready), 0);
    cyc(1);
    check_eq("t4_rdata_clr", if_rdata, 0);
    cyc(1);
    check_eq("t4_no_rdy", 32'(if_ready), 0);
    rst_n = 1'b1;
    cyc(1);
    check_eq("t4_reissue_en", 32'(ram_en), 1);
    check_eq("t4_reissue_addr", ram_addr, 32'h64);
    cyc(2);
    check_eq("t4_full_lat", 32'(if_ready), 0);
    cyc(1);
    check_eq("t4_rdy", 32'(if_ready), 1);
    check_eq("t4_rdata", if_rdata, 32'h2008_0004);
    if_req = 1'b0;
    cyc(2);

    // 5: MEM held against IF for a window of 30 cycles
    if_req = 1'b1; if_addr = 32'h64;
    mem_rd = 1'b1; mem_addr = 32'h1F4;
    mem_cnt = 0; if_cnt = 0; if_idx = -1; stall_low = 0;
    for (int i = 0; i < 30; i++) begin
      cyc(1);
      if (mem_ready) mem_cnt++;
      if (if_ready) begin
        if_cnt++;
        if (if_idx < 0) if_idx = i;
      end
      if (!stall_if) stall_low++;
    end
    check_eq("t5_mem_cnt", 32'(mem_cnt), 32'(EXP_MEM_CNT));
    check_eq("t5_if_cnt", 32'(if_cnt), 32'(EXP_IF_CNT));
    check_eq("t5_if_idx", 32'(if_idx), 32'(EXP_IF_IDX));
    check_eq("t5_stall_low", 32'(stall_low), 32'(EXP_IF_CNT));
    check_eq("t5_mem_rdata", mem_rdata, 32'd30);
    mem_rd = 1'b0;
    got_ready = 1'b0;
    for (int i = 0; i < 12 && !got_ready; i++) begin
      cyc(1);
      if (if_ready) got_ready = 1'b1;
    end
    check_eq("t5_if_after", 32'(got_ready), 1);
    if_req = 1'b0;
    cyc(2);

    // 6: IF held, address switched on ready
    if_req = 1'b1; if_addr = 32'h64;
    cyc(1);
    check_eq("t6_addr1", ram_addr, 32'h64);
    cyc(3);
    check_eq("t6_rdy1", 32'(if_ready), 1);
    check_eq("t6_resp_no_en", 32'(ram_en), 0);
    if_addr = 32'h68;
    cyc(1);
    check_eq("t6_g4_no_en", 32'(ram_en), 0);
    cyc(1);
    check_eq("t6_g5_en", 32'(ram_en), 1);
    check_eq("t6_addr2", ram_addr, 32'h68);
    cyc(3);
    check_eq("t6_rdy2", 32'(if_ready), 1);
    check_eq("t6_rdata2", if_rdata, 32'h8C09_0008);
    if_req = 1'b0;
    cyc(2);

    // 7: MEM request dropped after grant, address changed
    mem_rd = 1'b1; mem_addr = 32'h1F4;
    cyc(1);
    check_eq("t7_en", 32'(ram_en), 1);
    mem_rd = 1'b0; mem_addr = 32'h10;
    cyc(1);
    check_eq("t7_addr_latched", ram_addr, 32'h1F4);
    check_eq("t7_stall_mem", 32'(stall_mem), 0);
    cyc(2);
    check_eq("t7_rdy", 32'(mem_ready), 1);
    check_eq("t7_rdata", mem_rdata, 32'd30);
    check_eq("t7_if_rdy", 32'(if_ready), 0);
    cyc(1);
    check_eq("t7_rdy_off", 32'(mem_ready), 0);
    cyc(1);
    check_eq("t7_no_new", 32'(ram_en), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares one unified single-port synchronous RAM between the IF stage (instruction fetch, read-only) and the MEM stage (load/store) of the 5-stage MIPS pipeline. It sequences each access through a fixed-latency RAM handshake. It returns data plus a one-cycle ready pulse to the granted requester, and raises per-stage stall outputs that the pipeline uses to hold PC, IF_ID and EXE_MEM while a requester waits.

Parameters:
ADDR_W, 32, address width (byte address, passed through unmodified)
DATA_W, 32, data width
MEM_LATENCY, 2, RAM read latency in cycles, legal range >= 1
STARVE_LIMIT, 4, consecutive MEM grants before IF is forced (optional feature only)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
if_req  in  1  IF read request, held until if_ready
if_addr  in  ADDR_W  IF address
if_rdata  out  DATA_W  IF read data, valid while if_ready
if_ready  out  1  one-cycle completion pulse to IF
mem_rd  in  1  MEM read request, held until mem_ready
mem_wr  in  1  MEM write request, held until mem_ready
mem_addr  in  ADDR_W  MEM address
mem_wdata  in  DATA_W  MEM write data
mem_rdata  out  DATA_W  MEM read data, valid while mem_ready
mem_ready  out  1  one-cycle completion pulse to MEM
stall_if  out  1  if_req & ~if_ready
stall_mem  out  1  (mem_rd|mem_wr) & ~mem_ready
ram_en  out  1  RAM access strobe
ram_we  out  1  RAM write enable, qualified by ram_en
ram_addr  out  ADDR_W  RAM address
ram_wdata  out  DATA_W  RAM write data
ram_rdata  in  DATA_W  RAM read data

Behaviour:
- One clock (clk). Reset is asynchronous and active-low (rst_n). Reset forces state IDLE, grant NONE, and zeroes all registered outputs (ram_*, *_ready, *_rdata). stall_* are combinational from inputs and ready.
- RAM contract: ram_en/ram_we/ram_addr/ram_wdata are sampled at edge E. Read data is stable on ram_rdata at edge E+MEM_LATENCY. A write is complete at edge E.
- FSM: IDLE -> ISSUE -> WAIT -> RESP -> IDLE. All outputs are Moore, registered.
- IDLE: at each edge, sample the requests.
  - mem_rd|mem_wr present: grant MEM.
  - Else if_req present: grant IF.
  - Latch addr, wdata and we (mem_wr) into holding registers, then go to ISSUE.
  - Nothing pending: stay in IDLE.
- ISSUE (1 cycle): ram_en=1, ram_we=latched we, ram_addr/ram_wdata from the holding registers. Load wait counter with MEM_LATENCY.
- WAIT (MEM_LATENCY cycles): ram_en=0. Counter decrements each edge. At the edge where the counter reaches 0, capture ram_rdata into the granted requester's rdata register and go to RESP.
- RESP (1 cycle): granted ready=1, and rdata is valid. No new request is sampled in this cycle, so a requester dropping its request at the end of the ready cycle is never re-served. Next state is IDLE.
- Latency: request sampled at edge G -> ready high during cycle [G+1+MEM_LATENCY, G+2+MEM_LATENCY). Continuously held requests are served one per MEM_LATENCY+3 cycles.
- Writes take the same FSM path. mem_rdata for a write is don't-care but is held at its previous value.
- Simultaneous IF and MEM requests: MEM has priority (older instruction).
- mem_rd and mem_wr both high: treated as a write. A simulation-only assertion flags it.
- A requester dropping its request before ready: the transaction still completes and the ready pulse is still issued. Addr/wdata changes after grant are ignored (latched).
- The ready of the non-granted requester stays 0.
- rdata registers hold their last captured value between transactions.
- rst_n asserted mid-transaction (ISSUE/WAIT/RESP): immediate abort, ram_en/ram_we drop asynchronously, no ready pulse. Requests still pending after release are re-arbitrated from IDLE.

Optional Feature:
ARB_STARVE_GUARD_EN
- Defined: a counter of consecutive MEM grants taken while if_req was pending. When it reaches STARVE_LIMIT, the next IDLE arbitration grants IF even if MEM requests. The counter clears on any IF grant, when if_req is low at grant, and on reset.
- Undefined: strict MEM priority, no counter logic.

Decomposition:
- Shared package mem_arb_pkg:
  - FSM state enum (IDLE, ISSUE, WAIT, RESP).
  - Grant encoding (GNT_NONE, GNT_IF, GNT_MEM).
  - Default width constants.
- One natural sub-module, arb_wait_counter: loadable down-counter with a zero flag, width $clog2(MEM_LATENCY+1). It is reused for the starve counter when the macro is defined.

Test Plan:
1. MEM_LATENCY=2; RAM[0x64]=0x20080004; if_req, if_addr=0x64 sampled at edge G -> ram_en=1, ram_we=0, ram_addr=0x64 in cycle G; if_ready high only in cycle G+3 with if_rdata=0x20080004; stall_if high in cycles G..G+2.
2. if_req (0x68) and mem_rd (0x1F4) together, RAM[0x1F4]=30 -> MEM served first (mem_rdata=30, mem_ready at G+3); IF ram_en at G+5, if_ready at G+8; stall_if high throughout.
3. mem_wr, addr=0x10, wdata=0xDEADBEEF -> ram_en=ram_we=1 at 0x10 for one cycle, mem_ready at G+3; a following mem_rd of 0x10 returns 0xDEADBEEF.
4. rst_n low during WAIT -> ram_en/ram_we/ready drop to 0 immediately, no ready pulse; after release, held if_req is re-issued with a fresh ram_en and full latency.
5. mem_rd held for 6 transactions with if_req high, STARVE_LIMIT=4 -> macro defined: IF granted after the 4th MEM completion; macro undefined: IF never granted while mem_rd stays high.
6. if_req held across two addresses (0x64 then 0x68 switched on ready) -> no ram_en in RESP cycle; second ram_en exactly 5 cycles after the first; 0x64 never re-read.
